// File: rtl/palette_bank_ctrl.sv
// Double-buffered 16-entry sprite palette with frame-synchronous commit/swap.
// Optional PALETTE_FADE_EN adds fade_level scaling of the looked-up colour.
module palette_bank_ctrl #(
  parameter int          IDX_W     = 4,
  parameter logic [11:0] KEY_COLOR = 12'hF0F
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             vsync_pulse,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [IDX_W-1:0] wr_index,
  input  logic [11:0]      wr_color,
  input  logic             wr_commit,
  output logic             commit_pending,
  output logic             active_bank,
  input  logic             rd_valid,
  input  logic [IDX_W-1:0] rd_index,
  output logic             rd_out_valid,
  output logic [3:0]       red,
  output logic [3:0]       green,
  output logic [3:0]       blue,
`ifdef PALETTE_FADE_EN
  input  logic [3:0]       fade_level,
`endif
  output logic             rd_transparent
);

  localparam int ENTRIES = 2**IDX_W;

  typedef enum logic [1:0] {IDLE, PENDING, COPY} state_t;

  state_t                             state, state_nxt;
  logic [IDX_W-1:0]                   cnt;
  logic [1:0][ENTRIES-1:0][11:0]      bank;
  logic                               shadow;
  logic                               wr_en, commit_set, swap, copy_en;
  logic [1:0]                         vld_pipe;
  logic [11:0]                        rd_color;
  logic [3:0]                         red_nxt, green_nxt, blue_nxt;

  assign shadow = ~active_bank;

  always_comb begin
    state_nxt  = state;
    wr_ready   = 1'b0;
    wr_en      = 1'b0;
    commit_set = 1'b0;
    swap       = 1'b0;
    copy_en    = 1'b0;
    case (state)
      IDLE: begin
        wr_ready = 1'b1;
        wr_en    = wr_valid;
        if (wr_commit) begin
          commit_set = 1'b1;
          state_nxt  = PENDING;
        end
      end
      PENDING: begin
        if (vsync_pulse) begin
          swap      = 1'b1;
          state_nxt = COPY;
        end
      end
      COPY: begin
        copy_en = 1'b1;
        if (&cnt) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state          <= IDLE;
      active_bank    <= 1'b0;
      commit_pending <= 1'b0;
      cnt            <= '0;
      for (int b = 0; b < 2; b++)
        for (int e = 0; e < ENTRIES; e++)
          bank[b][e] <= (e == 0) ? KEY_COLOR : 12'h000;
    end else begin
      state <= state_nxt;
      if (wr_en) bank[shadow][wr_index] <= wr_color;
      if (commit_set) commit_pending <= 1'b1;
      if (swap) begin
        active_bank    <= ~active_bank;
        commit_pending <= 1'b0;
        cnt            <= '0;
      end
      // active_bank already points at the new bank here, so shadow is the old one
      if (copy_en) begin
        bank[shadow][cnt] <= bank[active_bank][cnt];
        cnt               <= cnt + 1'b1;
      end
    end
  end

  assign rd_color = bank[active_bank][rd_index];

`ifdef PALETTE_FADE_EN
  function automatic logic [3:0] fade(input logic [3:0] c, input logic [3:0] lvl);
    logic [7:0] p;
    p = {4'd0, c} * ({4'd0, lvl} + 8'd1);
    return p[7:4];
  endfunction

  always_comb begin
    red_nxt   = fade(rd_color[11:8], fade_level);
    green_nxt = fade(rd_color[7:4],  fade_level);
    blue_nxt  = fade(rd_color[3:0],  fade_level);
  end
`else
  always_comb begin
    red_nxt   = rd_color[11:8];
    green_nxt = rd_color[7:4];
    blue_nxt  = rd_color[3:0];
  end
`endif

  assign vld_pipe[0]  = rd_valid;
  assign rd_out_valid = vld_pipe[1];

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      vld_pipe[1]    <= 1'b0;
      red            <= '0;
      green          <= '0;
      blue           <= '0;
      rd_transparent <= 1'b0;
    end else begin
      vld_pipe[1] <= vld_pipe[0];
      if (rd_valid) begin
        red            <= red_nxt;
        green          <= green_nxt;
        blue           <= blue_nxt;
        rd_transparent <= (rd_color == KEY_COLOR);
      end
    end
  end

endmodule
